// File: rtl/csa_pkg.sv
// Shared types and elaboration helpers for the pipelined carry-select adder.
// Optional feature macro: CSA_OVF_EN (signed overflow output).
package csa_pkg;

  // Per-stage control state; wide operand and sum bits live beside it in the stage.
  typedef struct packed {
    logic valid;
    logic carry;
  } csa_ctl_t;

  function automatic int csa_nstg(input int width, input int blk);
    if (blk < 1) begin
      return 1;
    end else begin
      return width / blk;
    end
  endfunction

  function automatic bit csa_cfg_ok(input int width, input int blk);
    if (blk < 1) begin
      return 1'b0;
    end else begin
      return (width >= blk) && ((width % blk) == 0);
    end
  endfunction

  // Stage k keeps only the B bits it has not consumed yet (WIDTH - k*BLK bits);
  // this is the offset of stage k's slice in the packed triangular B store.
  function automatic int csa_boff(input int width, input int blk, input int stg);
    return stg * width - (blk * stg * (stg - 1)) / 2;
  endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: two BLK-bit sums (carry-in 0 and 1) and a select mux.
module csa_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           sel_cin,
  output logic [BLK-1:0] sum,
  output logic           cout
);

  logic [BLK:0] sum0_s;
  logic [BLK:0] sum1_s;

  // Both candidate sums are formed up front; the late-arriving carry only drives the mux.
  always_comb begin
    sum0_s = {1'b0, a} + {1'b0, b};
    sum1_s = {1'b0, a} + {1'b0, b} + {{BLK{1'b0}}, 1'b1};
    if (sel_cin) begin
      {cout, sum} = sum1_s;
    end else begin
      {cout, sum} = sum0_s;
    end
  end

endmodule

// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder/subtractor, one register stage per BLK-bit block,
// valid/ready flow control with a global stall. Define CSA_OVF_EN for out_ovf.
module csa_pipe_adder
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef CSA_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam bit CFG_OK = csa_cfg_ok(WIDTH, BLK);
  localparam int NSTG   = csa_nstg(WIDTH, BLK);
  localparam int BTOT   = csa_boff(WIDTH, BLK, NSTG);
  localparam int LOFF   = csa_boff(WIDTH, BLK, NSTG - 1);

  if (!CFG_OK) begin : g_bad_cfg
    $error("csa_pipe_adder: WIDTH must be a positive multiple of BLK");
  end

  logic             stall_s;
  csa_ctl_t         ctl_q_s [NSTG];
  logic [WIDTH-1:0] sa_out_s [NSTG];
  logic             cout_s [NSTG];
  logic [BTOT-1:0]  b_q_s;
`ifdef CSA_OVF_EN
  logic             last_a_msb_s;
`endif

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int BW   = WIDTH - k * BLK;
    localparam int BOFF = csa_boff(WIDTH, BLK, k);

    // sa_r holds finished sum bits below block k and untouched A bits from block k up.
    csa_ctl_t         ctl_r;
    logic [WIDTH-1:0] sa_r;
    logic [BW-1:0]    b_r;
    logic [BLK-1:0]   blk_sum_s;
    logic [WIDTH-1:0] sa_nx_s;

    assign ctl_q_s[k]        = ctl_r;
    assign b_q_s[BOFF +: BW] = b_r;
    assign sa_out_s[k]       = sa_nx_s;

    csa_block #(.BLK(BLK)) u_blk (
      .a       (sa_r[k*BLK +: BLK]),
      .b       (b_q_s[BOFF +: BLK]),
      .sel_cin (ctl_q_s[k].carry),
      .sum     (blk_sum_s),
      .cout    (cout_s[k])
    );

    // Splice this block's result into the A/sum word.
    always_comb begin
      sa_nx_s              = sa_r;
      sa_nx_s[k*BLK +: BLK] = blk_sum_s;
    end

    if (k == 0) begin : g_head
      // Subtraction is folded in here: invert B and force the carry-in.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ctl_r <= '0;
          sa_r  <= '0;
          b_r   <= '0;
        end else if (!stall_s) begin
          ctl_r.valid <= in_valid;
          ctl_r.carry <= in_sub | in_cin;
          sa_r        <= in_a;
          b_r         <= in_sub ? ~in_b : in_b;
        end
      end
    end else begin : g_tail
      localparam int PBOFF = csa_boff(WIDTH, BLK, k - 1);

      // Advance from the previous stage, dropping the B block it just consumed.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ctl_r <= '0;
          sa_r  <= '0;
          b_r   <= '0;
        end else if (!stall_s) begin
          ctl_r.valid <= ctl_q_s[k-1].valid;
          ctl_r.carry <= cout_s[k-1];
          sa_r        <= sa_out_s[k-1];
          b_r         <= b_q_s[PBOFF + BLK +: BW];
        end
      end
    end

`ifdef CSA_OVF_EN
    if (k == NSTG - 1) begin : g_msb
      assign last_a_msb_s = sa_r[WIDTH-1];
    end
`endif
  end

  // Output register; holds its contents while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef CSA_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (!stall_s) begin
      out_valid <= ctl_q_s[NSTG-1].valid;
      out_sum   <= sa_out_s[NSTG-1];
      out_cout  <= cout_s[NSTG-1];
`ifdef CSA_OVF_EN
      // Sign bits of A and effective B are still intact in the last stage.
      out_ovf   <= (last_a_msb_s == b_q_s[LOFF + BLK - 1]) &
                   (sa_out_s[NSTG-1][WIDTH-1] != last_a_msb_s);
`endif
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Scoreboard bench for csa_pipe_adder: 16/4 directed tests, 32/8 and 32/1 random
// traffic with backpressure. Honours CSA_OVF_EN for the overflow output.
`timescale 1ns/1ps
module tb_csa_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } dir_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  logic        v16, ir16, c16, s16, ov16, or16, co16;
  logic [15:0] a16, b16, sum16;
  logic        iv32, cin32, sub32, or32;
  logic [31:0] a32, b32;
  logic        ir8, ov8, co8, ir1, ov1, co1;
  logic [31:0] sum8, sum1;
`ifdef CSA_OVF_EN
  logic        ovf16, ovf8, ovf1;
`endif

  exp_t q16[$];
  exp_t q8[$];
  exp_t q1[$];

  csa_pipe_adder #(.WIDTH(16), .BLK(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(ir16), .in_a(a16), .in_b(b16),
    .in_cin(c16), .in_sub(s16), .out_valid(ov16), .out_ready(or16), .out_sum(sum16),
    .out_cout(co16)
`ifdef CSA_OVF_EN
    , .out_ovf(ovf16)
`endif
  );

  csa_pipe_adder #(.WIDTH(32), .BLK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir8), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov8), .out_ready(or32), .out_sum(sum8),
    .out_cout(co8)
`ifdef CSA_OVF_EN
    , .out_ovf(ovf8)
`endif
  );

  csa_pipe_adder #(.WIDTH(32), .BLK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir1), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .in_sub(sub32), .out_valid(ov1), .out_ready(or32), .out_sum(sum1),
    .out_cout(co1)
`ifdef CSA_OVF_EN
    , .out_ovf(ovf1)
`endif
  );

  // Reference: plain modular add, or subtract with borrow taken from a magnitude compare.
  function automatic exp_t model(input logic [31:0] a_in, input logic [31:0] b_in,
                                 input logic cin, input logic sub, input int w);
    logic [31:0] mask, a, b, r;
    logic [32:0] full;
    exp_t        e;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    a = a_in & mask;
    b = b_in & mask;
    if (sub) begin
      r      = (a - b) & mask;
      e.cout = (a >= b);
      e.ovf  = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
    end else begin
      full   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
      r      = full[31:0] & mask;
      e.cout = full[w];
      e.ovf  = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
    end
    e.sum = r;
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (ov16 !== 1'b0 || sum16 !== 16'h0000 || co16 !== 1'b0)
      begin errors++; $display("FAIL reset16: valid=%b sum=%h cout=%b, wanted 0/0000/0", ov16, sum16, co16); end
    checks++;
    if (ir16 !== 1'b1) begin errors++; $display("FAIL reset_ready: in_ready=%b, wanted 1", ir16); end
    checks++;
    if (ov8 !== 1'b0 || ov1 !== 1'b0 || sum8 !== 32'd0 || sum1 !== 32'd0)
      begin errors++; $display("FAIL reset32: valid8=%b valid1=%b sum8=%h sum1=%h, wanted zeros", ov8, ov1, sum8, sum1); end
`ifdef CSA_OVF_EN
    checks++;
    if (ovf16 !== 1'b0) begin errors++; $display("FAIL reset_ovf: ovf=%b, wanted 0", ovf16); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h4321; c16 = 1'b0; s16 = 1'b0; v16 = 1'b1; or16 = 1'b1;
    @(posedge clk);
    #1 v16 = 1'b0;
    @(negedge clk);
    lat = 0;
    while (ov16 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL latency: got %0d cycles, wanted 4", lat); end
    checks++;
    if (sum16 !== 16'h5555 || co16 !== 1'b0)
      begin errors++; $display("FAIL latency_value: sum=%h cout=%b, wanted 5555/0", sum16, co16); end
  endtask

  task automatic test_arith();
    dir_t ops[10];
    exp_t e;
    int   idx = 0, cyc = 0, got = 0;
    ops[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    ops[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    ops[2] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
    ops[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    ops[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    ops[5] = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
    ops[6] = '{16'h1234, 16'h0001, 1'b1, 1'b0, 16'h1236, 1'b0, 1'b0};
    ops[7] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    ops[8] = '{16'hABCD, 16'h5432, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    ops[9] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    or16 = 1'b1;
    while ((idx < 10 || q16.size() > 0) && cyc < 100) begin
      @(negedge clk);
      if (idx < 10) begin
        a16 = ops[idx].a; b16 = ops[idx].b; c16 = ops[idx].cin; s16 = ops[idx].sub; v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      #1;
      if (ov16 === 1'b1 && or16) begin
        e = q16.pop_front();
        checks++;
        if (sum16 !== e.sum[15:0] || co16 !== e.cout)
          begin errors++; $display("FAIL arith[%0d]: sum=%h cout=%b, wanted %h/%b", got, sum16, co16, e.sum[15:0], e.cout); end
`ifdef CSA_OVF_EN
        checks++;
        if (ovf16 !== e.ovf) begin errors++; $display("FAIL arith_ovf[%0d]: ovf=%b, wanted %b", got, ovf16, e.ovf); end
`endif
        got++;
      end
      if (v16 && ir16) begin
        q16.push_back('{{16'h0000, ops[idx].sum}, ops[idx].cout, ops[idx].ovf});
        idx++;
      end
      cyc++;
    end
    checks++;
    if (got != 10 || q16.size() != 0)
      begin errors++; $display("FAIL arith_count: got %0d results (%0d pending), wanted 10/0", got, q16.size()); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] oa[8], ob[8];
    logic        osub[8];
    exp_t        e;
    logic        exp_rdy;
    int          idx = 0, cyc = 0, got = 0;
    for (int i = 0; i < 8; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom); osub[i] = i[0];
    end
    while ((idx < 8 || q16.size() > 0) && cyc < 60) begin
      @(negedge clk);
      or16 = !(cyc >= 5 && cyc <= 7);
      if (idx < 8) begin
        a16 = oa[idx]; b16 = ob[idx]; c16 = 1'b0; s16 = osub[idx]; v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      #1;
      exp_rdy = !(cyc >= 5 && cyc <= 7);
      checks++;
      if (ir16 !== exp_rdy) begin errors++; $display("FAIL b2b_ready[cyc %0d]: in_ready=%b, wanted %b", cyc, ir16, exp_rdy); end
      if (ov16 === 1'b1 && !or16) begin
        checks++;
        if (q16.size() == 0 || sum16 !== q16[0].sum[15:0])
          begin errors++; $display("FAIL b2b_hold[cyc %0d]: sum=%h not held at expected head", cyc, sum16); end
      end else if (ov16 === 1'b1) begin
        checks++;
        if (q16.size() == 0) begin
          errors++; $display("FAIL b2b_extra[cyc %0d]: sum=%h with nothing outstanding", cyc, sum16);
        end else begin
          e = q16.pop_front();
          if (sum16 !== e.sum[15:0] || co16 !== e.cout)
            begin errors++; $display("FAIL b2b[%0d]: sum=%h cout=%b, wanted %h/%b", got, sum16, co16, e.sum[15:0], e.cout); end
          got++;
        end
      end
      if (v16 && ir16) begin
        q16.push_back(model({16'h0000, oa[idx]}, {16'h0000, ob[idx]}, 1'b0, osub[idx], 16));
        idx++;
      end
      cyc++;
    end
    or16 = 1'b1;
    checks++;
    if (got != 8 || q16.size() != 0)
      begin errors++; $display("FAIL b2b_count: got %0d results (%0d pending), wanted 8/0", got, q16.size()); end
  endtask

  task automatic test_reset_flight();
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a16 = 16'h0100 + 16'(i); b16 = 16'h0011; c16 = 1'b0; s16 = 1'b0; v16 = 1'b1;
    end
    @(negedge clk);
    v16 = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (ov16 !== 1'b0 || sum16 !== 16'h0000 || co16 !== 1'b0 || ir16 !== 1'b1)
      begin errors++; $display("FAIL flight_reset: valid=%b sum=%h cout=%b ready=%b, wanted 0/0000/0/1", ov16, sum16, co16, ir16); end
    rst_n = 1'b1;
    q16.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (ov16 !== 1'b0) begin errors++; $display("FAIL flight_stale[%0d]: out_valid=%b sum=%h, wanted no result", i, ov16, sum16); end
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   got8 = 0, got1 = 0;
    for (int cyc = 0; cyc < 14060; cyc++) begin
      @(negedge clk);
      if (cyc < 14000) begin
        iv32  = ($urandom_range(0, 99) < 85);
        a32   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b32   = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
        cin32 = 1'($urandom);
        sub32 = ($urandom_range(0, 99) < 40);
        or32  = ($urandom_range(0, 99) < 75);
      end else begin
        iv32 = 1'b0; or32 = 1'b1;
      end
      #1;
      if (ov8 === 1'b1 && or32) begin
        checks++;
        if (q8.size() == 0) begin
          errors++; $display("FAIL rand8_extra: sum=%h with nothing outstanding", sum8);
        end else begin
          e = q8.pop_front();
          if (sum8 !== e.sum || co8 !== e.cout)
            begin errors++; $display("FAIL rand8[%0d]: sum=%h cout=%b, wanted %h/%b", got8, sum8, co8, e.sum, e.cout); end
`ifdef CSA_OVF_EN
          else if (ovf8 !== e.ovf) begin errors++; $display("FAIL rand8_ovf[%0d]: ovf=%b, wanted %b", got8, ovf8, e.ovf); end
`endif
          got8++;
        end
      end
      if (ov1 === 1'b1 && or32) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL rand1_extra: sum=%h with nothing outstanding", sum1);
        end else begin
          e = q1.pop_front();
          if (sum1 !== e.sum || co1 !== e.cout)
            begin errors++; $display("FAIL rand1[%0d]: sum=%h cout=%b, wanted %h/%b", got1, sum1, co1, e.sum, e.cout); end
`ifdef CSA_OVF_EN
          else if (ovf1 !== e.ovf) begin errors++; $display("FAIL rand1_ovf[%0d]: ovf=%b, wanted %b", got1, ovf1, e.ovf); end
`endif
          got1++;
        end
      end
      if (iv32 && ir8) q8.push_back(model(a32, b32, cin32, sub32, 32));
      if (iv32 && ir1) q1.push_back(model(a32, b32, cin32, sub32, 32));
    end
    checks++;
    if (q8.size() != 0 || q1.size() != 0 || got8 < 8000 || got1 < 8000)
      begin errors++; $display("FAIL rand_drain: results %0d/%0d, pending %0d/%0d", got8, got1, q8.size(), q1.size()); end
  endtask

  initial begin
    rst_n = 1'b0;
    v16 = 1'b0; a16 = 16'h0; b16 = 16'h0; c16 = 1'b0; s16 = 1'b0; or16 = 1'b1;
    iv32 = 1'b0; a32 = 32'h0; b32 = 32'h0; cin32 = 1'b0; sub32 = 1'b0; or32 = 1'b1;
    test_reset();
    test_latency();
    test_arith();
    test_back_to_back();
    test_reset_flight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/csa_pipe_adder.md
# csa_pipe_adder

Parametrised, pipelined carry-select adder/subtractor, WIDTH bits split into BLK-bit carry-select blocks with one register stage per block. It is the successor to the 4-bit combinational carry-select adder and gives datapath blocks a throughput-of-one adder with valid/ready flow control. It sits between operand-producing logic and any consumer that can apply backpressure.

## Interface
- WIDTH, 16, operand and sum width; must be a multiple of BLK
- BLK, 4, carry-select block width in bits; NSTG = WIDTH/BLK pipeline stages
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands valid
- in_ready  out  1  adder can accept operands this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_cin  in  1  carry-in; ignored when in_sub=1
- in_sub  in  1  0: A+B+cin; 1: A−B (A + ~B + 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_sum  out  WIDTH  result
- out_cout  out  1  carry-out; for subtract, 1 = no borrow (A ≥ B unsigned)
- out_ovf  out  1  signed overflow; present only with CSA_OVF_EN

## Operation
- Stage k (k = 0..NSTG−1) computes bits [k·BLK +: BLK] with two BLK-bit ripple sums (carry-in 0 and 1) and selects by the carry registered from stage k−1; stage 0 selects by effective cin (in_sub ? 1 : in_cin).
- Effective B = in_sub ? ~in_b : in_b, formed at input, before stage 0.
- Each stage register holds: valid bit, block carry, completed low sum bits, remaining upper A/B bits. Upper operand bits shift forward unchanged.
- Global stall: stall = out_valid & ~out_ready. When stall=0 all stages advance one position; when stall=1 every stage register holds.
- in_ready = ~stall (combinational from out_valid/out_ready). Transfer on in_valid & in_ready. in_valid=0 on advance inserts a bubble (valid=0); bubbles are not collapsed.
- Results leave in issue order; no reordering, no dropping except on reset.
- Arithmetic modulo 2^WIDTH; out_cout is carry out of bit WIDTH−1.
- WIDTH % BLK ≠ 0 or BLK < 1: elaboration error.

## Timing
- Latency: NSTG cycles from input acceptance edge to out_valid=1 (WIDTH=16, BLK=4: 4 cycles).
- Throughput: one result per cycle while out_ready=1.
- out_* are registered outputs, stable while out_valid & ~out_ready.
- Reset (rst_n=0 at a rising edge): all stage valid bits 0, out_valid 0, out_sum 0, out_cout 0, out_ovf 0; in_ready=1 in the cycle after reset. In-flight operations are discarded; no result emerges after reset for operands accepted before it.
- Simultaneous output accept and input accept in a full pipeline: both occur same cycle, no bubble.
- in_ready rises in the same cycle out_ready rises.

## Configuration
- CSA_OVF_EN defined: out_ovf port exists; out_ovf = (a_msb == b_eff_msb) & (sum_msb ≠ a_msb), carried with its result through the pipeline.
- Undefined: no out_ovf port, no associated pipeline bits.

## Structure
- Package csa_pkg: NSTG derivation function, width-check constant, stage-register struct type (valid, carry, partial sum, upper operands, ovf sign bits).
- Sub-module csa_block: BLK-bit dual ripple plus select mux (inputs a, b, sel_cin; outputs sum, cout); instantiated NSTG times via generate.

## Test plan
- WIDTH=16, BLK=4, add 0xFFFF + 0x0001, cin=0 -> after 4 cycles out_sum=0x0000, out_cout=1.
- Subtract 0x0005 − 0x0007 -> out_sum=0xFFFE, out_cout=0; subtract 0x0007 − 0x0005 -> 0x0002, out_cout=1.
- CSA_OVF_EN: 0x7FFF + 0x0001 -> out_sum=0x8000, out_ovf=1; 0x8000 − 0x0001 -> 0x7FFF, out_ovf=1; 0x0003+0x0004 -> out_ovf=0.
- Back-to-back 8 operations, out_ready low for cycles 5–7 -> in_ready low same cycles, results in order, none lost or duplicated, out_sum stable during stall.
- Reset asserted with 3 operations in flight -> next cycle out_valid=0, all outputs 0, no stale result ever emitted.
- Random 10k operations, WIDTH=32, BLK=8 and BLK=1, random backpressure -> match reference model A±B±cin.
